// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES engine arbiter.
// A source id tags every block so the engine's in-order results can be steered back.
package aes_arb_pkg;

  typedef logic src_id_t;

  localparam src_id_t SRC_REQ0 = 1'b0;
  localparam src_id_t SRC_REQ1 = 1'b1;
  localparam int      N_REQ    = 2;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// AXI-Stream style block channel used for requester, engine and result ports.
interface aes_core_arbiter_if #(
  parameter int DATA_W = 128
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/aes_core_arbiter_tag_fifo.sv
// Small synchronous FIFO holding the source tag of each block inside the engine.
// Push while full is accepted only when a pop happens in the same cycle.
module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one in-order AES engine between two block requesters.
// Results are steered back by the source tag recorded when each block entered the engine.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  aes_core_arbiter_if.slave           s0,
  aes_core_arbiter_if.slave           s1,
  aes_core_arbiter_if.master          m_core,
  aes_core_arbiter_if.slave           s_core,
  aes_core_arbiter_if.master          m0,
  aes_core_arbiter_if.master          m1,
  output logic [cnt_w(MAX_OUT)-1:0]   outstanding,
  output logic                        err_orphan
);

  localparam int OW = cnt_w(MAX_OUT);

  logic              core_v;
  logic [DATA_W-1:0] core_d;
  src_id_t           core_src;
  src_id_t           rr;

  logic              slot_free;
  logic              can_grant;
  logic              grant0;
  logic              grant1;
  logic              grant;
  logic              core_hs;
  logic              deliver;
  logic              fifo_empty;
  logic              fifo_full;
  src_id_t           head;

  assign slot_free = !core_v || m_core.tready;
  assign can_grant = !rst && en && slot_free && !fifo_full &&
                     (outstanding < OW'(MAX_OUT));

  // Each ready looks only at the other requester's valid, never its own.
  assign s0.tready = can_grant && (!s1.tvalid || rr == SRC_REQ0);
  assign s1.tready = can_grant && (!s0.tvalid || rr == SRC_REQ1);

  assign grant0  = s0.tvalid && s0.tready;
  assign grant1  = s1.tvalid && s1.tready;
  assign grant   = grant0 || grant1;
  assign core_hs = core_v && m_core.tready;

  assign m_core.tvalid = core_v;
  assign m_core.tdata  = core_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_v   <= 1'b0;
      core_d   <= '0;
      core_src <= SRC_REQ0;
      rr       <= SRC_REQ0;
    end else if (grant) begin
      core_v   <= 1'b1;
      core_d   <= grant1 ? s1.tdata : s0.tdata;
      core_src <= grant1 ? SRC_REQ1 : SRC_REQ0;
      rr       <= grant1 ? SRC_REQ0 : SRC_REQ1;
    end else if (core_hs) begin
      core_v <= 1'b0;
    end
  end

  tag_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (core_hs),
    .din   (core_src),
    .pop   (deliver),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // With no tag waiting, a result has no owner: accept it so it is dropped.
  assign s_core.tready = !rst &&
                         (fifo_empty || (head == SRC_REQ1 ? m1.tready : m0.tready));
  assign deliver       = s_core.tvalid && s_core.tready && !fifo_empty;

  assign m0.tvalid = !rst && s_core.tvalid && !fifo_empty && (head == SRC_REQ0);
  assign m1.tvalid = !rst && s_core.tvalid && !fifo_empty && (head == SRC_REQ1);
  assign m0.tdata  = rst ? '0 : s_core.tdata;
  assign m1.tdata  = rst ? '0 : s_core.tdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({grant, deliver})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_orphan <= 1'b0;
    else if (s_core.tvalid && fifo_empty) err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter; the engine is played by hand from the stimulus.
module tb_aes_core_arbiter;

  localparam int DW = 128;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] outstanding;
  logic       err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  aes_core_arbiter_if #(.DATA_W(DW)) s0_if ();
  aes_core_arbiter_if #(.DATA_W(DW)) s1_if ();
  aes_core_arbiter_if #(.DATA_W(DW)) mc_if ();
  aes_core_arbiter_if #(.DATA_W(DW)) sc_if ();
  aes_core_arbiter_if #(.DATA_W(DW)) m0_if ();
  aes_core_arbiter_if #(.DATA_W(DW)) m1_if ();

  aes_core_arbiter #(.DATA_W(DW), .MAX_OUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s0          (s0_if),
    .s1          (s1_if),
    .m_core      (mc_if),
    .s_core      (sc_if),
    .m0          (m0_if),
    .m1          (m1_if),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  localparam logic [DW-1:0] A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] K  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [DW-1:0] B0 = 128'hb0b0b0b0_00000000_00000000_00000000;
  localparam logic [DW-1:0] B1 = 128'hb1b1b1b1_00000000_00000000_00000001;
  localparam logic [DW-1:0] B2 = 128'hb2b2b2b2_00000000_00000000_00000002;
  localparam logic [DW-1:0] R0 = 128'hc0c0c0c0_11111111_22222222_33333333;
  localparam logic [DW-1:0] R1 = 128'hc1c1c1c1_44444444_55555555_66666666;
  localparam logic [DW-1:0] R2 = 128'hc2c2c2c2_77777777_88888888_99999999;

  initial begin
    int eng;
    int ngr;
    int g0c;
    int g1c;
    logic exp_src;
    logic src;

    rst = 1'b1; en = 1'b0;
    s0_if.tvalid = 0; s0_if.tdata = '0;
    s1_if.tvalid = 0; s1_if.tdata = '0;
    mc_if.tready = 0;
    sc_if.tvalid = 0; sc_if.tdata = '0;
    m0_if.tready = 1; m1_if.tready = 1;
    step(); step();

    chk("rst_s0_tready", s0_if.tready, 0);
    chk("rst_sc_tready", sc_if.tready, 0);
    chk("rst_mc_tvalid", mc_if.tvalid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_orphan", err_orphan, 0);
    rst = 1'b0; en = 1'b1;

    // Single requester through a 3-cycle engine
    mc_if.tready = 1;
    s0_if.tvalid = 1; s0_if.tdata = A;
    #1 chk("single_s0_tready", s0_if.tready, 1);
    step();
    s0_if.tvalid = 0;
    #1;
    chk("single_mc_tvalid", mc_if.tvalid, 1);
    chk("single_mc_tdata", mc_if.tdata, A);
    chk("single_out1", outstanding, 1);
    step();
    chk("single_mc_done", mc_if.tvalid, 0);
    step(); step();
    sc_if.tvalid = 1; sc_if.tdata = A ^ K;
    #1;
    chk("single_m0_tvalid", m0_if.tvalid, 1);
    chk("single_m0_tdata", m0_if.tdata, A ^ K);
    chk("single_m1_tvalid", m1_if.tvalid, 0);
    chk("single_sc_tready", sc_if.tready, 1);
    step();
    sc_if.tvalid = 0;
    chk("single_out0", outstanding, 0);

    // Fairness: both requesters always valid, engine returns each block a cycle later
    do_reset();
    s0_if.tvalid = 1; s0_if.tdata = B0;
    s1_if.tvalid = 1; s1_if.tdata = B1;
    mc_if.tready = 1;
    eng = 0; ngr = 0; g0c = 0; g1c = 0; exp_src = 1'b0;
    for (int c = 0; c < 200 && ngr < 16; c++) begin
      sc_if.tvalid = (eng > 0); sc_if.tdata = R0;
      #1;
      if ((s0_if.tvalid && s0_if.tready) || (s1_if.tvalid && s1_if.tready)) begin
        src = s1_if.tvalid && s1_if.tready;
        chk("fair_order", src, exp_src);
        exp_src = ~exp_src;
        if (src) g1c++; else g0c++;
        ngr++;
      end
      chk("fair_limit", (outstanding > 3'd4), 0);
      eng = eng + int'(mc_if.tvalid && mc_if.tready) - int'(sc_if.tvalid && sc_if.tready);
      step();
    end
    s0_if.tvalid = 0; s1_if.tvalid = 0;
    chk("fair_total", ngr, 16);
    chk("fair_g0", g0c, 8);
    chk("fair_g1", g1c, 8);
    for (int c = 0; c < 30; c++) begin
      sc_if.tvalid = (eng > 0);
      #1;
      eng = eng + int'(mc_if.tvalid && mc_if.tready) - int'(sc_if.tvalid && sc_if.tready);
      step();
      if (eng == 0 && !mc_if.tvalid) break;
    end
    sc_if.tvalid = 0;
    chk("fair_drained", outstanding, 0);
    chk("fair_no_orphan", err_orphan, 0);

    // In-flight limit with results stalled
    s0_if.tvalid = 1; s1_if.tvalid = 1;
    ngr = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if ((s0_if.tvalid && s0_if.tready) || (s1_if.tvalid && s1_if.tready)) ngr++;
      step();
    end
    chk("limit_grants", ngr, 4);
    chk("limit_s0_tready", s0_if.tready, 0);
    chk("limit_s1_tready", s1_if.tready, 0);
    chk("limit_out4", outstanding, 4);
    sc_if.tvalid = 1;
    #1 chk("limit_release_rdy", sc_if.tready, 1);
    step();
    sc_if.tvalid = 0;
    ngr = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if ((s0_if.tvalid && s0_if.tready) || (s1_if.tvalid && s1_if.tready)) ngr++;
      step();
    end
    chk("limit_one_more", ngr, 1);
    chk("limit_out4_again", outstanding, 4);
    s0_if.tvalid = 0; s1_if.tvalid = 0;
    for (int i = 0; i < 4; i++) begin
      sc_if.tvalid = 1;
      #1 chk("limit_drain_rdy", sc_if.tready, 1);
      step();
    end
    sc_if.tvalid = 0;
    chk("limit_out0", outstanding, 0);

    // Routing with requester-1 result backpressure: issue s1, s0, s1
    do_reset();
    mc_if.tready = 1;
    s1_if.tvalid = 1; s1_if.tdata = B1;
    #1 chk("route_s1a_rdy", s1_if.tready, 1);
    step();
    s1_if.tvalid = 0; s0_if.tvalid = 1; s0_if.tdata = B0;
    #1;
    chk("route_mc_b1", mc_if.tdata, B1);
    chk("route_s0_rdy", s0_if.tready, 1);
    step();
    s0_if.tvalid = 0; s1_if.tvalid = 1; s1_if.tdata = B2;
    #1;
    chk("route_mc_b0", mc_if.tdata, B0);
    chk("route_s1b_rdy", s1_if.tready, 1);
    step();
    s1_if.tvalid = 0;
    step();
    m0_if.tready = 1; m1_if.tready = 0;
    sc_if.tvalid = 1; sc_if.tdata = R1;
    #1;
    chk("route_hold_rdy", sc_if.tready, 0);
    chk("route_hold_m1v", m1_if.tvalid, 1);
    chk("route_hold_m0v", m0_if.tvalid, 0);
    step();
    chk("route_hold_rdy2", sc_if.tready, 0);
    chk("route_out3", outstanding, 3);
    m1_if.tready = 1;
    #1;
    chk("route_r1_rdy", sc_if.tready, 1);
    chk("route_r1_data", m1_if.tdata, R1);
    step();
    sc_if.tdata = R0;
    #1;
    chk("route_r0_m0v", m0_if.tvalid, 1);
    chk("route_r0_m1v", m1_if.tvalid, 0);
    chk("route_r0_data", m0_if.tdata, R0);
    step();
    sc_if.tdata = R2;
    #1;
    chk("route_r2_m1v", m1_if.tvalid, 1);
    chk("route_r2_m0v", m0_if.tvalid, 0);
    step();
    sc_if.tvalid = 0;
    chk("route_out0", outstanding, 0);

    // Disable with two blocks in the engine and one in the slot
    mc_if.tready = 1;
    s0_if.tvalid = 1; s0_if.tdata = A;
    step(); step(); step();
    en = 0; mc_if.tready = 0;
    #1;
    chk("dis_s0_rdy", s0_if.tready, 0);
    chk("dis_slot_v", mc_if.tvalid, 1);
    chk("dis_out3", outstanding, 3);
    step();
    chk("dis_slot_held", mc_if.tvalid, 1);
    mc_if.tready = 1;
    step();
    chk("dis_slot_taken", mc_if.tvalid, 0);
    for (int i = 0; i < 3; i++) begin
      sc_if.tvalid = 1; sc_if.tdata = K;
      #1;
      chk("dis_res_rdy", sc_if.tready, 1);
      chk("dis_res_m0v", m0_if.tvalid, 1);
      chk("dis_no_grant", s0_if.tready, 0);
      step();
    end
    sc_if.tvalid = 0;
    chk("dis_out0", outstanding, 0);
    s0_if.tvalid = 0;
    en = 1;

    // Orphan result, then async reset mid-transfer
    sc_if.tvalid = 1;
    #1;
    chk("orph_rdy", sc_if.tready, 1);
    chk("orph_m0v", m0_if.tvalid, 0);
    chk("orph_m1v", m1_if.tvalid, 0);
    step();
    sc_if.tvalid = 0;
    #1 chk("orph_err", err_orphan, 1);
    mc_if.tready = 0;
    s0_if.tvalid = 1; s0_if.tdata = B0;
    step();
    chk("rst2_pre_out", outstanding, 1);
    chk("rst2_pre_mcv", mc_if.tvalid, 1);
    #3 rst = 1'b1;
    #1;
    chk("rst2_mcv", mc_if.tvalid, 0);
    chk("rst2_s0_rdy", s0_if.tready, 0);
    chk("rst2_s1_rdy", s1_if.tready, 0);
    chk("rst2_sc_rdy", sc_if.tready, 0);
    chk("rst2_out", outstanding, 0);
    chk("rst2_err", err_orphan, 0);
    s0_if.tvalid = 0;
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
